// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble validity check used by the counter
// and by the board's 7-segment decoder.
package bcd_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic is_bcd(input logic [3:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, counts up or down when enabled, and flags when the
// next decade must be stepped.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_val,
   input  logic             cnt_en,
   input  logic             up_dn,
   output logic [BCD_W-1:0] digit,
   output logic             wrap_out
);

   logic [BCD_W-1:0] r_digit;

   // Load has already been validated upstream, so ld_val is always a BCD nibble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_digit <= BCD_MIN;
      end else if (load) begin
         r_digit <= ld_val;
      end else if (cnt_en) begin
         if (up_dn) begin
            r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
         end else begin
            r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
         end
      end
   end

   assign digit    = r_digit;
   assign wrap_out = cnt_en && (up_dn ? (r_digit == BCD_MAX) : (r_digit == BCD_MIN));

endmodule

// File: rtl/bcd_counter_multi.sv
// N-digit BCD up/down counter on the system clock, gated by a prescaler tick,
// with validated parallel load and optional saturation at the limits.
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 1,
   parameter int SATURATE = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count_out,
   output logic                  tick,
   output logic                  carry,
   output logic                  borrow,
   output logic                  at_limit,
   output logic                  load_err
);

   localparam int             PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  P_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]     r_presc;
   logic              r_carry;
   logic              r_borrow;
   logic              r_loadErr;
   logic [DIGITS-1:0] w_wrap;
   logic [DIGITS-1:0] w_digOk;
   logic [DIGITS-1:0] w_isMax;
   logic [DIGITS-1:0] w_isMin;
   logic              w_loadOk;
   logic              w_loadGood;
   logic              w_satBlock;
   logic              w_cnt0;

   // Prescaler restarts from zero whenever counting is not permitted.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         r_presc <= '0;
      end else if (r_presc == P_LAST) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   assign tick = enable && (r_presc == P_LAST);

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic w_en;

      if (g == 0) begin : g_first
         assign w_en = w_cnt0;
      end else begin : g_chain
         assign w_en = w_wrap[g-1];
      end

      bcd_digit u_digit (
         .clk      (clk),
         .reset    (reset),
         .load     (w_loadGood),
         .ld_val   (load_val[g*BCD_W +: BCD_W]),
         .cnt_en   (w_en),
         .up_dn    (up_dn),
         .digit    (count_out[g*BCD_W +: BCD_W]),
         .wrap_out (w_wrap[g])
      );

      assign w_digOk[g] = is_bcd(load_val[g*BCD_W +: BCD_W]);
      assign w_isMax[g] = (count_out[g*BCD_W +: BCD_W] == BCD_MAX);
      assign w_isMin[g] = (count_out[g*BCD_W +: BCD_W] == BCD_MIN);
   end

   assign at_limit   = up_dn ? (&w_isMax) : (&w_isMin);
   assign w_loadOk   = &w_digOk;
   assign w_loadGood = load && w_loadOk;
   assign w_satBlock = (SATURATE != 0) && at_limit;
   // Any load request, accepted or rejected, swallows a coincident tick.
   assign w_cnt0     = tick && !load && !w_satBlock;

   // The last decade wrapping means the whole count rolled over.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_carry   <= 1'b0;
         r_borrow  <= 1'b0;
         r_loadErr <= 1'b0;
      end else begin
         r_carry   <= up_dn && w_wrap[DIGITS-1];
         r_borrow  <= !up_dn && w_wrap[DIGITS-1];
         r_loadErr <= load && !w_loadOk;
      end
   end

   assign carry    = r_carry;
   assign borrow   = r_borrow;
   assign load_err = r_loadErr;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Self-checking bench: a 2-digit wrapping counter checked against an integer
// model, plus a saturating instance exercised with fixed expectations.
module tb_bcd_counter_multi;

   localparam int DIGITS   = 2;
   localparam int TICK_DIV = 3;
   localparam int W        = 4 * DIGITS;
   localparam int MAXV     = 10**DIGITS - 1;

   logic         clk = 1'b0;
   logic         reset, enable, up_dn, load;
   logic [W-1:0] load_val;
   logic [W-1:0] count_out;
   logic         tick, carry, borrow, at_limit, load_err;

   logic         sReset, sEnable, sUpDn, sLoad;
   logic [W-1:0] sLoadVal;
   logic [W-1:0] sCount;
   logic         sTick, sCarry, sBorrow, sAtLimit, sErr;

   int nChecks = 0;
   int nFails  = 0;

   int   mCount, mPresc;
   logic mCarry, mBorrow, mErr;

   bcd_counter_multi #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SATURATE(0)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count_out(count_out), .tick(tick), .carry(carry),
      .borrow(borrow), .at_limit(at_limit), .load_err(load_err)
   );

   bcd_counter_multi #(.DIGITS(DIGITS), .TICK_DIV(1), .SATURATE(1)) u_sat (
      .clk(clk), .reset(sReset), .enable(sEnable), .up_dn(sUpDn), .load(sLoad),
      .load_val(sLoadVal), .count_out(sCount), .tick(sTick), .carry(sCarry),
      .borrow(sBorrow), .at_limit(sAtLimit), .load_err(sErr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [W-1:0] toBcd(input int v);
      logic [W-1:0] r;
      int           x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int fromBcd(input logic [W-1:0] v);
      int r;
      r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic bit validBcd(input logic [W-1:0] v);
      for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit mTick();
      return enable && (mPresc == TICK_DIV - 1);
   endfunction

   function automatic bit mAtLimit();
      return up_dn ? (mCount == MAXV) : (mCount == 0);
   endfunction

   // Advance one clock edge and move the model to its post-edge state.
   task automatic cycle();
      int   nc, np;
      logic c, b, e;
      bit   tk;
      nc = mCount;
      c  = 1'b0;
      b  = 1'b0;
      e  = 1'b0;
      tk = mTick();
      np = enable ? ((mPresc + 1) % TICK_DIV) : 0;
      if (reset) begin
         nc = 0;
         np = 0;
      end else if (load) begin
         if (validBcd(load_val)) nc = fromBcd(load_val);
         else e = 1'b1;
      end else if (tk) begin
         if (up_dn) begin
            if (nc == MAXV) begin nc = 0; c = 1'b1; end
            else nc = nc + 1;
         end else begin
            if (nc == 0) begin nc = MAXV; b = 1'b1; end
            else nc = nc - 1;
         end
      end
      @(posedge clk);
      #1;
      mCount  = nc;
      mPresc  = np;
      mCarry  = c;
      mBorrow = b;
      mErr    = e;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h42;
      sReset = 1'b1; sEnable = 1'b0; sUpDn = 1'b1; sLoad = 1'b0; sLoadVal = '0;
      mCount = 0; mPresc = 0; mCarry = 0; mBorrow = 0; mErr = 0;
      cycle();
      cycle();
      nChecks++;
      if (count_out !== 8'h00) begin nFails++; $display("[TB] FAIL reset_count: got %h expected 00", count_out); end
      nChecks++;
      if ({carry, borrow, load_err} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_pulses: got %b expected 000", {carry, borrow, load_err}); end
      nChecks++;
      if (tick !== 1'b0) begin nFails++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
      nChecks++;
      if (sCount !== 8'h00) begin nFails++; $display("[TB] FAIL reset_sat_count: got %h expected 00", sCount); end
      reset = 1'b0; load = 1'b0; sReset = 1'b0;
   endtask

   task automatic test_count_up();
      up_dn = 1'b1; enable = 1'b1; load = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle();
         nChecks++;
         if (count_out !== toBcd(mCount)) begin nFails++; $display("[TB] FAIL up_count: got %h expected %h", count_out, toBcd(mCount)); end
         nChecks++;
         if (tick !== mTick()) begin nFails++; $display("[TB] FAIL up_tick: got %b expected %b", tick, mTick()); end
      end
      nChecks++;
      if (count_out !== 8'h10) begin nFails++; $display("[TB] FAIL up_ripple: got %h expected 10", count_out); end
   endtask

   task automatic test_wrap_up();
      int pulses = 0;
      up_dn = 1'b1; load = 1'b1; load_val = 8'h99;
      cycle();
      load = 1'b0;
      nChecks++;
      if (at_limit !== 1'b1) begin nFails++; $display("[TB] FAIL wrap_limit: got %b expected 1", at_limit); end
      for (int i = 0; i < 2 * TICK_DIV; i++) begin
         cycle();
         pulses += int'(carry);
         nChecks++;
         if (carry !== mCarry) begin nFails++; $display("[TB] FAIL wrap_carry: got %b expected %b", carry, mCarry); end
      end
      nChecks++;
      if (pulses != 1) begin nFails++; $display("[TB] FAIL wrap_pulses: got %0d expected 1", pulses); end
      nChecks++;
      if (count_out !== 8'h01) begin nFails++; $display("[TB] FAIL wrap_count: got %h expected 01", count_out); end
   endtask

   task automatic test_count_down();
      int pulses = 0;
      up_dn = 1'b0; load = 1'b1; load_val = 8'h00;
      cycle();
      load = 1'b0;
      nChecks++;
      if (at_limit !== 1'b1) begin nFails++; $display("[TB] FAIL down_limit: got %b expected 1", at_limit); end
      for (int i = 0; i < 2 * TICK_DIV; i++) begin
         cycle();
         pulses += int'(borrow);
         nChecks++;
         if (borrow !== mBorrow) begin nFails++; $display("[TB] FAIL down_borrow: got %b expected %b", borrow, mBorrow); end
      end
      nChecks++;
      if (pulses != 1) begin nFails++; $display("[TB] FAIL down_pulses: got %0d expected 1", pulses); end
      nChecks++;
      if (count_out !== 8'h98) begin nFails++; $display("[TB] FAIL down_count: got %h expected 98", count_out); end
      load = 1'b1; load_val = 8'h10;
      cycle();
      load = 1'b0;
      for (int i = 0; i < TICK_DIV; i++) cycle();
      nChecks++;
      if (count_out !== 8'h09) begin nFails++; $display("[TB] FAIL down_ripple: got %h expected 09", count_out); end
   endtask

   task automatic test_load_reject();
      int guard;
      up_dn = 1'b1; load = 1'b1; load_val = 8'h37;
      cycle();
      load_val = 8'h5A;
      cycle();
      load = 1'b0;
      nChecks++;
      if (count_out !== 8'h37) begin nFails++; $display("[TB] FAIL reject_count: got %h expected 37", count_out); end
      nChecks++;
      if (load_err !== 1'b1) begin nFails++; $display("[TB] FAIL reject_err: got %b expected 1", load_err); end
      load = 1'b1; load_val = 8'h42;
      cycle();
      load = 1'b0;
      nChecks++;
      if (count_out !== 8'h42) begin nFails++; $display("[TB] FAIL accept_count: got %h expected 42", count_out); end
      nChecks++;
      if (load_err !== 1'b0) begin nFails++; $display("[TB] FAIL accept_err: got %b expected 0", load_err); end
      guard = 0;
      while (!mTick() && guard < TICK_DIV + 2) begin cycle(); guard++; end
      nChecks++;
      if (tick !== 1'b1) begin nFails++; $display("[TB] FAIL reject_wait_tick: got %b expected 1", tick); end
      load = 1'b1; load_val = 8'hA0;
      cycle();
      load = 1'b0;
      nChecks++;
      if (count_out !== toBcd(mCount) || count_out !== 8'h42) begin nFails++; $display("[TB] FAIL reject_on_tick: got %h expected 42", count_out); end
   endtask

   task automatic test_load_tick();
      int guard;
      up_dn = 1'b1; load = 1'b1; load_val = 8'h99;
      cycle();
      load = 1'b0;
      guard = 0;
      while (!mTick() && guard < TICK_DIV + 2) begin cycle(); guard++; end
      nChecks++;
      if (tick !== 1'b1) begin nFails++; $display("[TB] FAIL ldtick_wait: got %b expected 1", tick); end
      load = 1'b1; load_val = 8'h23;
      cycle();
      load = 1'b0;
      nChecks++;
      if (count_out !== 8'h23) begin nFails++; $display("[TB] FAIL ldtick_count: got %h expected 23", count_out); end
      nChecks++;
      if (carry !== 1'b0) begin nFails++; $display("[TB] FAIL ldtick_carry: got %b expected 0", carry); end
      enable = 1'b0;
      cycle();
      cycle();
      enable = 1'b1;
      #1;
      for (int i = 1; i <= 3; i++) begin
         nChecks++;
         if (tick !== (i == 3)) begin nFails++; $display("[TB] FAIL enable_tick_%0d: got %b expected %b", i, tick, (i == 3)); end
         if (i < 3) cycle();
      end
      cycle();
      nChecks++;
      if (count_out !== 8'h24) begin nFails++; $display("[TB] FAIL enable_first_count: got %h expected 24", count_out); end
   endtask

   task automatic test_reset_mid();
      int guard;
      up_dn = 1'b1;
      guard = 0;
      while (mPresc != TICK_DIV - 2 && guard < TICK_DIV + 2) begin cycle(); guard++; end
      load = 1'b1; load_val = 8'hFF;
      cycle();
      nChecks++;
      if (load_err !== 1'b1 || tick !== 1'b1) begin nFails++; $display("[TB] FAIL rst_setup: got err=%b tick=%b expected 1 1", load_err, tick); end
      reset = 1'b1; load_val = 8'h55;
      cycle();
      nChecks++;
      if (count_out !== 8'h00) begin nFails++; $display("[TB] FAIL rst_mid_count: got %h expected 00", count_out); end
      nChecks++;
      if ({carry, borrow, load_err} !== 3'b000) begin nFails++; $display("[TB] FAIL rst_mid_pulses: got %b expected 000", {carry, borrow, load_err}); end
      reset = 1'b0; load = 1'b0;
      for (int i = 1; i <= TICK_DIV; i++) begin
         cycle();
         nChecks++;
         if (count_out !== toBcd(i / TICK_DIV)) begin nFails++; $display("[TB] FAIL rst_resume_%0d: got %h expected %h", i, count_out, toBcd(i / TICK_DIV)); end
      end
   endtask

   task automatic test_saturate();
      enable = 1'b0;
      sLoad = 1'b1; sLoadVal = 8'h99; sUpDn = 1'b1;
      cycle();
      sLoad = 1'b0; sEnable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         nChecks++;
         if (sCount !== 8'h99 || sCarry !== 1'b0 || sAtLimit !== 1'b1) begin nFails++; $display("[TB] FAIL sat_hold_up: got %h carry=%b lim=%b expected 99 0 1", sCount, sCarry, sAtLimit); end
      end
      sUpDn = 1'b0;
      #1;
      nChecks++;
      if (sAtLimit !== 1'b0) begin nFails++; $display("[TB] FAIL sat_limit_dir: got %b expected 0", sAtLimit); end
      cycle();
      nChecks++;
      if (sCount !== 8'h98) begin nFails++; $display("[TB] FAIL sat_down_step: got %h expected 98", sCount); end
      sLoad = 1'b1; sLoadVal = 8'h00;
      cycle();
      sLoad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         nChecks++;
         if (sCount !== 8'h00 || sBorrow !== 1'b0) begin nFails++; $display("[TB] FAIL sat_hold_down: got %h borrow=%b expected 00 0", sCount, sBorrow); end
      end
      sEnable = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset  = ($urandom_range(0, 60) == 0);
         enable = ($urandom_range(0, 5) != 0);
         up_dn  = ($urandom_range(0, 3) != 0);
         load   = ($urandom_range(0, 12) == 0);
         load_val = ($urandom_range(0, 2) != 0) ? toBcd($urandom_range(0, MAXV)) : W'($urandom);
         #1;
         nChecks++;
         if (tick !== mTick() || at_limit !== mAtLimit()) begin nFails++; $display("[TB] FAIL rnd_comb: got tick=%b lim=%b expected %b %b", tick, at_limit, mTick(), mAtLimit()); end
         cycle();
         nChecks++;
         if (count_out !== toBcd(mCount)) begin nFails++; $display("[TB] FAIL rnd_count: got %h expected %h", count_out, toBcd(mCount)); end
         nChecks++;
         if ({carry, borrow, load_err} !== {mCarry, mBorrow, mErr}) begin nFails++; $display("[TB] FAIL rnd_pulses: got %b expected %b", {carry, borrow, load_err}, {mCarry, mBorrow, mErr}); end
      end
      reset = 1'b0; load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap_up();
      test_count_down();
      test_load_reject();
      test_load_tick();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
